// File: rtl/textbuf_pkg.sv
// Shared definitions for the text buffer writer: FSM state encoding,
// character/control code constants and the RAM address width.
package textbuf_pkg;

   localparam int unsigned ADDR_W = 16;

   localparam logic [7:0] CH_BS        = 8'h08;
   localparam logic [7:0] CH_LF        = 8'h0A;
   localparam logic [7:0] CH_CR        = 8'h0D;
   localparam logic [7:0] CH_SPACE     = 8'h20;
   localparam logic [7:0] CH_PRINT_MIN = 8'h20;
   localparam logic [7:0] CH_PRINT_MAX = 8'h7E;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_CTRL,
      ST_CLEAR,
      ST_LINECLR
   } state_t;

   function automatic logic is_printable(input logic [7:0] c);
      return (c >= CH_PRINT_MIN) && (c <= CH_PRINT_MAX);
   endfunction

endpackage

// File: rtl/textbuf_writer_cursor.sv
// Cursor counters for the text buffer writer: row, column and the running
// line base address (row*max_columns kept incrementally, no multiplier).
module textbuf_cursor
   import textbuf_pkg::*;
(
   input  logic              CLK_108MHz,
   input  logic              reset,
   input  logic [7:0]        max_rows,
   input  logic [7:0]        max_columns,
   input  logic              cmd_advance,
   input  logic              cmd_newline,
   input  logic              cmd_cr,
   input  logic              cmd_bs,
   input  logic              cmd_home,
   output logic [7:0]        row,
   output logic [7:0]        col,
   output logic [ADDR_W-1:0] line_base,
   output logic              at_last_col
);

   logic at_last_row;

   assign at_last_col = (col == max_columns - 8'd1);
   assign at_last_row = (row == max_rows - 8'd1);

   always_ff @(posedge CLK_108MHz or posedge reset) begin
      if (reset) begin
         row       <= '0;
         col       <= '0;
         line_base <= '0;
      end else if (cmd_home) begin
         row       <= '0;
         col       <= '0;
         line_base <= '0;
      end else if (cmd_newline || (cmd_advance && at_last_col)) begin
         // A printable in the last column wraps exactly like LF.
         col <= '0;
         if (at_last_row) begin
            row       <= '0;
            line_base <= '0;
         end else begin
            row       <= row + 8'd1;
            line_base <= line_base + ADDR_W'(max_columns);
         end
      end else if (cmd_advance) begin
         col <= col + 8'd1;
      end else if (cmd_cr) begin
         col <= '0;
      end else if (cmd_bs && (col != '0)) begin
         col <= col - 8'd1;
      end
   end

endmodule

// File: rtl/textbuf_writer.sv
// Cursor-based character RAM writer; writes only while disp_active is low.
// Optional hardware scroll is enabled by defining TEXTBUF_SCROLL_EN.
module textbuf_writer
   import textbuf_pkg::*;
(
   input  logic              CLK_108MHz,
   input  logic              reset,
   input  logic [7:0]        max_rows,
   input  logic [7:0]        max_columns,
   input  logic              char_valid,
   input  logic [7:0]        char_data,
   output logic              char_ready,
   input  logic              clear_req,
   input  logic              disp_active,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   output logic [7:0]        cursor_row,
   output logic [7:0]        cursor_col,
   output logic [7:0]        top_row,
   output logic              busy
);

   state_t            state;
   logic              clr_pend;
   logic [7:0]        char_q;
   logic [ADDR_W-1:0] clr_addr;
   logic [7:0]        clr_row;
   logic [7:0]        clr_col;
   logic [ADDR_W-1:0] line_base;
   logic              at_last_col;
   logic              slot_free;
   logic              clr_last;
   logic              line_last;
   logic              cmd_advance, cmd_newline, cmd_cr, cmd_bs, cmd_home;

   assign slot_free = !disp_active;
   assign clr_last  = (clr_row == max_rows - 8'd1) && (clr_col == max_columns - 8'd1);
   assign line_last = (clr_col == max_columns - 8'd1);

`ifdef TEXTBUF_SCROLL_EN
   logic [7:0]        top_q;
   logic [7:0]        last_vis;
   logic              newline_now;
   logic [ADDR_W-1:0] new_line_base;

   assign last_vis      = (top_q == '0) ? max_rows - 8'd1 : top_q - 8'd1;
   assign newline_now   = ((state == ST_WRITE) && at_last_col) ||
                          ((state == ST_CTRL) && (char_q == CH_LF));
   // The physical row after the last visible one is always the old top row.
   assign new_line_base = (cursor_row == max_rows - 8'd1) ? '0
                                                          : line_base + ADDR_W'(max_columns);
   assign top_row       = top_q;
`else
   assign top_row = '0;
`endif

   assign cmd_advance = (state == ST_WRITE) && slot_free;
   assign cmd_newline = (state == ST_CTRL) && (char_q == CH_LF);
   assign cmd_cr      = (state == ST_CTRL) && (char_q == CH_CR);
   assign cmd_bs      = (state == ST_CTRL) && (char_q == CH_BS);
   assign cmd_home    = (state == ST_CLEAR) && slot_free && clr_last;

   textbuf_cursor u_cursor (
      .CLK_108MHz  (CLK_108MHz),
      .reset       (reset),
      .max_rows    (max_rows),
      .max_columns (max_columns),
      .cmd_advance (cmd_advance),
      .cmd_newline (cmd_newline),
      .cmd_cr      (cmd_cr),
      .cmd_bs      (cmd_bs),
      .cmd_home    (cmd_home),
      .row         (cursor_row),
      .col         (cursor_col),
      .line_base   (line_base),
      .at_last_col (at_last_col)
   );

   always_ff @(posedge CLK_108MHz or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         clr_pend <= 1'b0;
         char_q   <= '0;
         clr_addr <= '0;
         clr_row  <= '0;
         clr_col  <= '0;
`ifdef TEXTBUF_SCROLL_EN
         top_q    <= '0;
`endif
      end else begin
         if (clear_req && (state != ST_CLEAR))
            clr_pend <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (clr_pend) begin
                  state    <= ST_CLEAR;
                  clr_addr <= '0;
                  clr_row  <= '0;
                  clr_col  <= '0;
               end else if (char_valid) begin
                  char_q <= char_data;
                  state  <= is_printable(char_data) ? ST_WRITE : ST_CTRL;
               end
            end
            ST_WRITE, ST_CTRL: begin
               if ((state == ST_CTRL) || slot_free) begin
                  state <= ST_IDLE;
`ifdef TEXTBUF_SCROLL_EN
                  if (newline_now && (cursor_row == last_vis)) begin
                     state    <= ST_LINECLR;
                     clr_addr <= new_line_base;
                     clr_col  <= '0;
                     top_q    <= (top_q == max_rows - 8'd1) ? '0 : top_q + 8'd1;
                  end
`endif
               end
            end
            ST_CLEAR: begin
               if (slot_free) begin
                  clr_addr <= clr_addr + ADDR_W'(1);
                  if (line_last) begin
                     clr_col <= '0;
                     clr_row <= clr_row + 8'd1;
                  end else begin
                     clr_col <= clr_col + 8'd1;
                  end
                  if (clr_last) begin
                     state    <= ST_IDLE;
                     clr_pend <= 1'b0;
`ifdef TEXTBUF_SCROLL_EN
                     top_q    <= '0;
`endif
                  end
               end
            end
            ST_LINECLR: begin
               if (slot_free) begin
                  clr_addr <= clr_addr + ADDR_W'(1);
                  clr_col  <= clr_col + 8'd1;
                  if (line_last)
                     state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // The write strobe is gated combinationally so it can never overlap disp_active.
   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      case (state)
         ST_WRITE: begin
            ram_we    = slot_free;
            ram_addr  = line_base + ADDR_W'(cursor_col);
            ram_wdata = char_q;
         end
         ST_CLEAR, ST_LINECLR: begin
            ram_we    = slot_free;
            ram_addr  = clr_addr;
            ram_wdata = CH_SPACE;
         end
         default: ;
      endcase
   end

   assign char_ready = (state == ST_IDLE) && !clr_pend && !reset;
   assign busy       = (state != ST_IDLE) || clr_pend;

endmodule

// File: tb/tb_textbuf_writer.sv
// Self-checking bench for textbuf_writer: directed vector table, multi-cycle
// corner sequences and randomized traffic against a shadow-screen model.
module tb_textbuf_writer;

`ifdef TEXTBUF_SCROLL_EN
   localparam bit SCROLL = 1'b1;
`else
   localparam bit SCROLL = 1'b0;
`endif

   logic        CLK_108MHz = 1'b0;
   logic        reset;
   logic [7:0]  max_rows, max_columns;
   logic        char_valid;
   logic [7:0]  char_data;
   logic        char_ready;
   logic        clear_req;
   logic        disp_active;
   logic        ram_we;
   logic [15:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic [7:0]  cursor_row, cursor_col, top_row;
   logic        busy;

   textbuf_writer dut (
      .CLK_108MHz  (CLK_108MHz),
      .reset       (reset),
      .max_rows    (max_rows),
      .max_columns (max_columns),
      .char_valid  (char_valid),
      .char_data   (char_data),
      .char_ready  (char_ready),
      .clear_req   (clear_req),
      .disp_active (disp_active),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .cursor_row  (cursor_row),
      .cursor_col  (cursor_col),
      .top_row     (top_row),
      .busy        (busy)
   );

   initial forever #5 CLK_108MHz = ~CLK_108MHz;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          overlap_cnt = 0;
   bit          rand_disp = 1'b0;
   logic [15:0] wq_addr[$];
   logic [7:0]  wq_data[$];
   logic [7:0]  dut_mem [0:4095];
   logic [7:0]  mdl_mem [0:4095];
   int          m_row, m_col, m_top, m_rows, m_cols;

   typedef struct {
      logic [7:0]  c;
      logic [7:0]  row;
      logic [7:0]  col;
      int          nwr;
      logic [15:0] addr;
   } vec_t;
   vec_t vecs[13];

   // Write capture, sampled mid-cycle.
   always @(negedge CLK_108MHz) begin
      if (ram_we) begin
         wq_addr.push_back(ram_addr);
         wq_data.push_back(ram_wdata);
         dut_mem[ram_addr[11:0]] = ram_wdata;
         if (disp_active) overlap_cnt++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   task automatic step();
      @(posedge CLK_108MHz);
      #1;
      if (rand_disp) disp_active = ($urandom_range(0, 2) == 0);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 5000) begin n++; step(); end
      if (busy) timeout("wait_idle");
   endtask

   task automatic send(input logic [7:0] c, output int low);
      int n = 0;
      while (!char_ready && n < 5000) begin n++; step(); end
      if (!char_ready) timeout("wait_ready");
      char_valid = 1'b1;
      char_data  = c;
      step();
      char_valid = 1'b0;
      low = 0;
      while (!char_ready && low < 5000) begin low++; step(); end
      if (!char_ready) timeout("ready_return");
   endtask

   task automatic pulse_clear();
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
   endtask

   task automatic set_geom(input int rows, input int cols);
      max_rows    = 8'(rows);
      max_columns = 8'(cols);
      m_rows      = rows;
      m_cols      = cols;
   endtask

   task automatic mdl_clear();
      for (int k = 0; k < m_rows * m_cols; k++) mdl_mem[k] = 8'h20;
      m_row = 0; m_col = 0; m_top = 0;
   endtask

   task automatic mdl_newline();
      m_col = 0;
      if (SCROLL && m_row == (m_top + m_rows - 1) % m_rows) begin
         m_top = (m_top + 1) % m_rows;
         m_row = (m_row + 1) % m_rows;
         for (int k = 0; k < m_cols; k++) mdl_mem[m_row * m_cols + k] = 8'h20;
      end else begin
         m_row = (m_row + 1) % m_rows;
      end
   endtask

   task automatic mdl_char(input logic [7:0] c);
      if (c >= 8'h20 && c <= 8'h7E) begin
         mdl_mem[m_row * m_cols + m_col] = c;
         if (m_col == m_cols - 1) mdl_newline();
         else m_col++;
      end else if (c == 8'h0A) mdl_newline();
      else if (c == 8'h0D) m_col = 0;
      else if (c == 8'h08 && m_col > 0) m_col--;
   endtask

   function automatic logic [7:0] pick_char();
      case ($urandom_range(0, 9))
         0: return 8'h0A;
         1: return 8'h0D;
         2: return 8'h08;
         3: return 8'($urandom_range(0, 31));
         4: return 8'($urandom_range(127, 255));
         default: return 8'($urandom_range(32, 126));
      endcase
   endfunction

   initial begin
      int lc, w0, n;
      logic [7:0] c;

      vecs[0]  = '{8'h41, 8'd0, 8'd1, 1, 16'd0};
      vecs[1]  = '{8'h42, 8'd0, 8'd2, 1, 16'd1};
      vecs[2]  = '{8'h0D, 8'd0, 8'd0, 0, 16'd0};
      vecs[3]  = '{8'h08, 8'd0, 8'd0, 0, 16'd0};
      vecs[4]  = '{8'h0A, 8'd1, 8'd0, 0, 16'd0};
      vecs[5]  = '{8'h43, 8'd1, 8'd1, 1, 16'd80};
      vecs[6]  = '{8'h08, 8'd1, 8'd0, 0, 16'd0};
      vecs[7]  = '{8'h01, 8'd1, 8'd0, 0, 16'd0};
      vecs[8]  = '{8'h44, 8'd1, 8'd1, 1, 16'd80};
      vecs[9]  = '{8'h0A, 8'd2, 8'd0, 0, 16'd0};
      vecs[10] = '{8'h7E, 8'd2, 8'd1, 1, 16'd160};
      vecs[11] = '{8'h7F, 8'd2, 8'd1, 0, 16'd0};
      vecs[12] = '{8'h1F, 8'd2, 8'd1, 0, 16'd0};

      reset = 1'b1; char_valid = 1'b0; char_data = '0; clear_req = 1'b0; disp_active = 1'b0;
      set_geom(4, 80);
      repeat (3) @(posedge CLK_108MHz);
      #1;
      check("rst_ready", char_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_we", ram_we, 0);
      check("rst_row", cursor_row, 0);
      check("rst_col", cursor_col, 0);
      check("rst_top", top_row, 0);
      reset = 1'b0;
      #1;
      check("rel_ready", char_ready, 1);

      // Directed vector table, 80x4.
      foreach (vecs[i]) begin
         w0 = wq_addr.size();
         send(vecs[i].c, lc);
         check("tbl_ready_low", lc, 1);
         check("tbl_row", cursor_row, vecs[i].row);
         check("tbl_col", cursor_col, vecs[i].col);
         check("tbl_nwrites", wq_addr.size() - w0, vecs[i].nwr);
         if (vecs[i].nwr == 1 && wq_addr.size() > w0) begin
            check("tbl_addr", wq_addr[$], vecs[i].addr);
            check("tbl_data", wq_data[$], vecs[i].c);
         end
      end

      // Display owns the port for 5 cycles after accepting 'X' at (2,1).
      w0 = wq_addr.size();
      n = 0;
      while (!char_ready && n < 100) begin n++; step(); end
      char_valid = 1'b1; char_data = 8'h58; disp_active = 1'b1;
      step();
      char_valid = 1'b0;
      repeat (5) step();
      check("stall_nowrite", wq_addr.size() - w0, 0);
      check("stall_busy", busy, 1);
      disp_active = 1'b0;
      lc = 5;
      while (!char_ready && lc < 100) begin lc++; step(); end
      check("stall_ready_low", lc, 6);
      check("stall_nwrites", wq_addr.size() - w0, 1);
      check("stall_addr", wq_addr[$], 161);
      check("stall_data", wq_data[$], 8'h58);
      check("stall_col", cursor_col, 2);

      // Last-column wrap at (1,79), then BS at col 0 and CR.
      pulse_clear();
      wait_idle();
      send(8'h0A, lc);
      for (int i = 0; i < 79; i++) send(8'h61, lc);
      check("wrap_pre_row", cursor_row, 1);
      check("wrap_pre_col", cursor_col, 79);
      wq_addr.delete(); wq_data.delete();
      send(8'h5A, lc);
      check("wrap_nwrites", wq_addr.size(), 1);
      check("wrap_addr", wq_addr[0], 159);
      check("wrap_row", cursor_row, 2);
      check("wrap_col", cursor_col, 0);
      send(8'h08, lc);
      check("bs0_row", cursor_row, 2);
      check("bs0_col", cursor_col, 0);
      for (int i = 0; i < 5; i++) send(8'h62, lc);
      check("cr_pre_col", cursor_col, 5);
      send(8'h0D, lc);
      check("cr_row", cursor_row, 2);
      check("cr_col", cursor_col, 0);

      // LF from the last row, 3 rows x 4 columns.
      set_geom(3, 4);
      pulse_clear();
      wait_idle();
      send(8'h0A, lc);
      send(8'h0A, lc);
      check("lf_pre_row", cursor_row, 2);
      wq_addr.delete(); wq_data.delete();
      send(8'h0A, lc);
      wait_idle();
      check("lf_row", cursor_row, 0);
      check("lf_col", cursor_col, 0);
      check("lf_top", top_row, SCROLL ? 1 : 0);
      check("lf_nwrites", wq_addr.size(), SCROLL ? 4 : 0);
      foreach (wq_addr[k]) begin
         check("lf_clr_addr", wq_addr[k], k);
         check("lf_clr_data", wq_data[k], 8'h20);
      end

      // Full clear on 4 columns x 3 rows, with a second request absorbed mid-clear.
      send(8'h51, lc);
      wq_addr.delete(); wq_data.delete();
      pulse_clear();
      check("clr_busy", busy, 1);
      n = 0;
      while (busy && n < 200) begin
         n++;
         clear_req = (n == 4);
         step();
      end
      clear_req = 1'b0;
      check("clr_cycles", n, 13);
      check("clr_nwrites", wq_addr.size(), 12);
      foreach (wq_addr[k]) begin
         check("clr_addr", wq_addr[k], k);
         check("clr_data", wq_data[k], 8'h20);
      end
      check("clr_row", cursor_row, 0);
      check("clr_col", cursor_col, 0);
      check("clr_top", top_row, 0);
      repeat (3) step();
      check("clr_busy_after", busy, 0);

      // Reset during a clear at the 6th write.
      send(8'h61, lc);
      send(8'h62, lc);
      wq_addr.delete(); wq_data.delete();
      pulse_clear();
      n = 0;
      while (wq_addr.size() < 6 && n < 200) begin n++; step(); end
      if (wq_addr.size() < 6) timeout("reset_wait");
      reset = 1'b1;
      #1;
      check("mid_rst_we", ram_we, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", char_ready, 0);
      check("mid_rst_col", cursor_col, 0);
      check("mid_rst_row", cursor_row, 0);
      check("mid_rst_top", top_row, 0);
      check("mid_rst_addr", ram_addr, 0);
      check("mid_rst_wdata", ram_wdata, 0);
      step();
      reset = 1'b0;
      #1;
      check("post_rst_ready", char_ready, 1);
      repeat (20) step();
      check("post_rst_nwrites", wq_addr.size(), 6);

      // Randomized traffic with random display contention.
      for (int r = 0; r < 3; r++) begin
         set_geom($urandom_range(1, 6), $urandom_range(1, 10));
         pulse_clear();
         wait_idle();
         mdl_clear();
         rand_disp = 1'b1;
         for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 39) == 0) begin
               pulse_clear();
               wait_idle();
               mdl_clear();
            end else begin
               c = pick_char();
               send(c, lc);
               mdl_char(c);
            end
            check("rnd_row", cursor_row, m_row);
            check("rnd_col", cursor_col, m_col);
            check("rnd_top", top_row, m_top);
         end
         rand_disp = 1'b0;
         disp_active = 1'b0;
         for (int k = 0; k < m_rows * m_cols; k++) check("rnd_mem", dut_mem[k], mdl_mem[k]);
      end

      check("we_with_disp", overlap_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
